bus_rr_mm: RTL and testbench

//  Parametrised shared bus: N_MASTER masters, N_SLAVE slaves, round-robin arbitration.

---
 rtl/bus_rr_mm_pkg.sv | 11 +
 rtl/bus_rr_mm_if.sv | 27 ++
 rtl/bus_rr_mm_rr_arbiter.sv | 39 +++
 rtl/bus_rr_mm.sv | 69 ++++++
 tb/tb_bus_rr_mm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/bus_rr_mm_pkg.sv
// bus_rr_mm_pkg: default widths, default address map and arbiter state encoding for bus_rr_mm.
package bus_rr_mm_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 64;
    localparam logic [2*DEF_ADDR_W-1:0] DEF_SLV_BASE = {16'h7000, 16'h0000};
    localparam logic [2*DEF_ADDR_W-1:0] DEF_SLV_MASK = {16'hFE00, 16'hF800};
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
    function automatic int idx_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bus_rr_mm_if.sv
// bus_rr_mm_if: master-side and slave-side signals of the shared bus.
// master/slave modports are agent views; fabric is the bus itself.
interface bus_rr_mm_if #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64
);
    logic [N_MASTER-1:0]        m_req;
    logic [N_MASTER-1:0]        m_wr;
    logic [N_MASTER*ADDR_W-1:0] m_addr;
    logic [N_MASTER*DATA_W-1:0] m_dout;
    logic [N_MASTER-1:0]        m_grant;
    logic [DATA_W-1:0]          m_din;
    logic                       m_err;
    logic [N_SLAVE-1:0]         s_sel;
    logic                       s_wr;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_din;
    logic [N_SLAVE*DATA_W-1:0]  s_dout;
    modport master (output m_req, m_wr, m_addr, m_dout, input m_grant, m_din, m_err);
    modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
    modport fabric (
        input  m_req, m_wr, m_addr, m_dout, s_dout,
        output m_grant, m_din, m_err, s_sel, s_wr, s_addr, s_din
    );
endinterface

// File: rtl/bus_rr_mm_rr_arbiter.sv
// rr_arbiter: registered one-hot round-robin grant; owner keeps the bus while owner_hold is high.
module rr_arbiter import bus_rr_mm_pkg::*; #(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         owner_hold,
    output logic [N-1:0] grant
);
    arb_state_t state;
    logic [IW-1:0] last_owner, nxt, j;
    logic found;
    // search starts just after the previous owner, wrapping modulo N
    always_comb begin
        nxt = last_owner;
        found = 1'b0;
        j = '0;
        for (int k = 1; k <= N; k++) begin
            j = IW'((int'(last_owner) + k) % N);
            if (!found && req[j]) begin
                nxt = j;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            last_owner <= IW'(N - 1);
        end else if (state == IDLE || !owner_hold) begin
            state <= found ? BUSY : IDLE;
            grant <= found ? N'(1) << nxt : '0;
            if (found) last_owner <= nxt;
        end
    end
endmodule

// File: rtl/bus_rr_mm.sv
// bus_rr_mm: round-robin shared bus, N_MASTER masters to N_SLAVE slaves via base/mask decode.
// Define BUS_DECERR_EN for a registered decode-error flag aligned with read data.
module bus_rr_mm import bus_rr_mm_pkg::*; #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter logic [N_SLAVE*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [N_SLAVE*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input logic clk,
    input logic reset_n,
    bus_rr_mm_if.fabric bus
);
    logic [N_MASTER-1:0] grant;
    logic [N_SLAVE-1:0]  hit, sel, sel_q;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata, rdata;
    logic                wr, granted;
    assign granted = |grant;
    rr_arbiter #(.N(N_MASTER)) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (bus.m_req),
        .owner_hold (|(grant & bus.m_req)),
        .grant      (grant)
    );
    always_comb begin
        addr = '0;
        wdata = '0;
        wr = 1'b0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (grant[i]) begin
                addr = bus.m_addr[i*ADDR_W +: ADDR_W];
                wdata = bus.m_dout[i*DATA_W +: DATA_W];
                wr = bus.m_wr[i];
            end
        end
    end
    for (genvar i = 0; i < N_SLAVE; i++) begin : g_dec
        assign hit[i] = (addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
    end
    // isolate the lowest hit so overlapping regions still give a one-hot select
    assign sel = granted ? hit & (~hit + N_SLAVE'(1)) : '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_q <= '0;
        else sel_q <= sel;
    end
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_SLAVE; i++) rdata = rdata | (sel_q[i] ? bus.s_dout[i*DATA_W +: DATA_W] : '0);
    end
`ifdef BUS_DECERR_EN
    logic err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else err_q <= granted & ~|sel;
    end
    assign bus.m_err = err_q;
`else
    assign bus.m_err = 1'b0;
`endif
    assign bus.m_grant = grant;
    assign bus.s_sel   = sel;
    assign bus.s_wr    = wr;
    assign bus.s_addr  = addr;
    assign bus.s_din   = wdata;
    assign bus.m_din   = rdata;
endmodule

// File: tb/tb_bus_rr_mm.sv
// tb_bus_rr_mm: directed and randomized checks of bus_rr_mm against a transaction-level model.
module tb_bus_rr_mm;
    localparam int NM = 2, NS = 2, AW = 16, DW = 64;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0, errors = 0;
    bus_rr_mm_if #(.N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
    bus_rr_mm #(
        .N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE(32'h7000_0000), .SLV_MASK(32'hFE00_F800)
    ) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    logic [AW-1:0] base [NS] = '{16'h0000, 16'h7000};
    logic [AW-1:0] mask [NS] = '{16'hF800, 16'hFE00};
    int owner, last, sel_prev;
    bit err_prev;
    bit exp_err_en;
    logic [AW-1:0] ra;
    bit rq, rw;
    function automatic int decode(logic [AW-1:0] a);
        for (int i = 0; i < NS; i++) if ((a & mask[i]) == base[i]) return i;
        return -1;
    endfunction
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        owner = -1;
        last = NM - 1;
        sel_prev = -1;
        err_prev = 1'b0;
    endtask
    // one bus cycle at transaction level: who owns the bus next and which slave answered
    task automatic model_edge();
        int nw;
        sel_prev = owner >= 0 ? decode(bus.m_addr[owner*AW +: AW]) : -1;
        err_prev = owner >= 0 && sel_prev < 0;
        if (!(owner >= 0 && bus.m_req[owner])) begin
            nw = -1;
            for (int k = 1; k <= NM; k++) if (nw < 0 && bus.m_req[(last + k) % NM]) nw = (last + k) % NM;
            owner = nw;
            if (nw >= 0) last = nw;
        end
    endtask
    task automatic check_all(string tag);
        int s;
        logic [63:0] e_grant, e_sel, e_addr, e_din, e_rd;
        logic e_wr;
        s = -1; e_grant = '0; e_sel = '0; e_addr = '0; e_din = '0; e_wr = 1'b0; e_rd = '0;
        if (owner >= 0) begin
            e_grant = 64'(1) << owner;
            e_addr = 64'(bus.m_addr[owner*AW +: AW]);
            e_din = bus.m_dout[owner*DW +: DW];
            e_wr = bus.m_wr[owner];
            s = decode(bus.m_addr[owner*AW +: AW]);
            if (s >= 0) e_sel = 64'(1) << s;
        end
        if (sel_prev >= 0) e_rd = bus.s_dout[sel_prev*DW +: DW];
        chk({tag, "_grant"}, 64'(bus.m_grant), e_grant);
        chk({tag, "_sel"}, 64'(bus.s_sel), e_sel);
        chk({tag, "_addr"}, 64'(bus.s_addr), e_addr);
        chk({tag, "_wr"}, 64'(bus.s_wr), 64'(e_wr));
        chk({tag, "_din"}, bus.s_din, e_din);
        chk({tag, "_mdin"}, bus.m_din, e_rd);
        chk({tag, "_err"}, 64'(bus.m_err), 64'(exp_err_en && err_prev));
    endtask
    task automatic cyc(string tag);
        #1 check_all(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask
    task automatic set_m(int i, bit req, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.m_req[i] = req;
        bus.m_wr[i] = wr;
        bus.m_addr[i*AW +: AW] = a;
        bus.m_dout[i*DW +: DW] = d;
    endtask
    task automatic do_reset();
        bus.m_req = '0;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask
    initial begin
`ifdef BUS_DECERR_EN
        exp_err_en = 1'b1;
`else
        exp_err_en = 1'b0;
`endif
        bus.m_req = '0; bus.m_wr = '0; bus.m_addr = '0; bus.m_dout = '0; bus.s_dout = '0;
        model_reset();
        @(posedge clk);
        #1 check_all("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_m(0, 1, 1, 16'h0000, '1);
        cyc("t1");
        chk("t1_grant_lit", 64'(bus.m_grant), 64'h1);
        chk("t1_sel_lit", 64'(bus.s_sel), 64'h1);
        chk("t1_wr_lit", 64'(bus.s_wr), 64'h1);
        chk("t1_din_lit", bus.s_din, 64'hFFFF_FFFF_FFFF_FFFF);
        set_m(0, 1, 0, 16'h07FF, '0);
        bus.s_dout = {64'hABCD_ABCD_ABCD_ABCD, 64'hDEAD_DEAD_DEAD_DEAD};
        cyc("t2a");
        chk("t2_rd0_lit", bus.m_din, 64'hDEAD_DEAD_DEAD_DEAD);
        set_m(0, 1, 0, 16'h7000, '0);
        cyc("t2b");
        chk("t2_sel1_lit", 64'(bus.s_sel), 64'h2);
        chk("t2_rd1_lit", bus.m_din, 64'hABCD_ABCD_ABCD_ABCD);
        do_reset();
        set_m(0, 1, 0, 16'h0010, 64'h11);
        set_m(1, 1, 1, 16'h7010, 64'h22);
        cyc("t3a");
        chk("t3_first_lit", 64'(bus.m_grant), 64'h1);
        set_m(0, 0, 0, 16'h0010, 64'h11);
        cyc("t3b");
        chk("t3_handover_lit", 64'(bus.m_grant), 64'h2);
        chk("t3_handover_sel_lit", 64'(bus.s_sel), 64'h2);
        set_m(1, 0, 1, 16'h7010, 64'h22);
        cyc("t3c");
        chk("t3_idle_lit", 64'(bus.m_grant), 64'h0);
        set_m(0, 1, 0, 16'h0010, 64'h11);
        set_m(1, 1, 1, 16'h7010, 64'h22);
        cyc("t3d");
        chk("t3_rr_lit", 64'(bus.m_grant), 64'h1);
        set_m(0, 0, 0, 16'h0010, 64'h11);
        cyc("t4a");
        set_m(0, 1, 0, 16'h0010, 64'h11);
        for (int c = 0; c < 10; c++) begin
            cyc("t4hold");
            chk("t4_hold_lit", 64'(bus.m_grant), 64'h2);
        end
        set_m(1, 0, 1, 16'h7010, 64'h22);
        cyc("t4b");
        chk("t4_release_lit", 64'(bus.m_grant), 64'h1);
        set_m(0, 1, 0, 16'h1000, 64'h33);
        cyc("t5");
        chk("t5_sel_lit", 64'(bus.s_sel), 64'h0);
        chk("t5_rd_lit", bus.m_din, 64'h0);
        chk("t5_err_lit", 64'(bus.m_err), 64'(exp_err_en));
        set_m(0, 1, 1, 16'h71FF, 64'h4444_5555_6666_7777);
        cyc("t6a");
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk("t6_grant_lit", 64'(bus.m_grant), 64'h0);
        chk("t6_sel_lit", 64'(bus.s_sel), 64'h0);
        chk("t6_wr_lit", 64'(bus.s_wr), 64'h0);
        chk("t6_err_lit", 64'(bus.m_err), 64'h0);
        check_all("t6rst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        set_m(1, 1, 0, 16'h7000, 64'h0);
        cyc("t6b");
        chk("t6_first_lit", 64'(bus.m_grant), 64'h1);
        for (int c = 0; c < 400; c++) begin
            for (int m = 0; m < NM; m++) begin
                rq = $urandom_range(0, 2) != 0;
                rw = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0: ra = AW'($urandom_range(0, 16'h07FF));
                    1: ra = AW'(16'h7000 + $urandom_range(0, 16'h01FF));
                    2: ra = 16'h1000;
                    default: ra = AW'($urandom);
                endcase
                set_m(m, rq, rw, ra, {$urandom, $urandom});
            end
            bus.s_dout = {$urandom, $urandom, $urandom, $urandom};
            cyc("rnd");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
